// File: rtl/sys_arr_bn_act.sv
// Batch-norm / ReLU post-processing stage behind the systolic array.
// Applies y = sat(round(x*scale) + shift) per lane over a 3-stage pipe.
module sys_arr_bn_act #(
    parameter int unsigned VECT_LEN = 8,
    parameter int unsigned DATA_WDT = 16,
    parameter int unsigned FRAC_WDT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clk_en,
    input  logic                         i_clear,
    input  logic                         i_start,
    input  logic                         i_bn_en,
    input  logic                         i_relu_en,
    input  logic                         i_in_val,
    input  logic [1:0]                   i_in_type,
    input  logic                         i_in_last,
    input  logic [VECT_LEN*DATA_WDT-1:0] i_in_data,
    output logic                         o_out_val,
    output logic [1:0]                   o_out_type,
    output logic                         o_out_last,
    output logic [VECT_LEN*DATA_WDT-1:0] o_out_data,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int unsigned PROD_W = 2 * DATA_WDT;
    localparam int unsigned SUM_W  = 2 * DATA_WDT + 2;

    localparam logic signed [DATA_WDT-1:0] UNITY     = {{(DATA_WDT-1){1'b0}}, 1'b1} << FRAC_WDT;
    localparam logic signed [SUM_W-1:0]    HALF      = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_WDT-1);
    localparam logic [DATA_WDT-1:0]        SAT_MAX_W = {1'b0, {(DATA_WDT-1){1'b1}}};
    localparam logic [DATA_WDT-1:0]        SAT_MIN_W = {1'b1, {(DATA_WDT-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]    SAT_MAX   = {{(SUM_W-DATA_WDT){1'b0}}, SAT_MAX_W};
    localparam logic signed [SUM_W-1:0]    SAT_MIN   = {{(SUM_W-DATA_WDT){1'b1}}, SAT_MIN_W};

    typedef enum logic [1:0] {StIdle, StLdScale, StLdShift, StProc} state_e;

    state_e r_state, w_state_nxt;

    logic w_is_data, w_is_bn, w_is_pass;
    logic w_acc, w_ld_scale, w_ld_shift, w_unity, w_cap, w_err_set;

    logic signed [DATA_WDT-1:0] r_scale [VECT_LEN];
    logic signed [DATA_WDT-1:0] r_shift [VECT_LEN];
    logic                       r_relu;
    logic                       r_err;

    logic signed [DATA_WDT-1:0] w_lane  [VECT_LEN];
    logic signed [PROD_W-1:0]   w_prod  [VECT_LEN];
    logic signed [DATA_WDT-1:0] w_shsel [VECT_LEN];

    logic                       r_s1_val, r_s1_last, r_s1_relu;
    logic [1:0]                 r_s1_type;
    logic signed [PROD_W-1:0]   r_s1_prod  [VECT_LEN];
    logic signed [DATA_WDT-1:0] r_s1_shift [VECT_LEN];

    logic signed [SUM_W-1:0]    w_pext [VECT_LEN];
    logic signed [SUM_W-1:0]    w_rnd  [VECT_LEN];
    logic signed [SUM_W-1:0]    w_sum  [VECT_LEN];

    logic                       r_s2_val, r_s2_last, r_s2_relu;
    logic [1:0]                 r_s2_type;
    logic signed [SUM_W-1:0]    r_s2_sum [VECT_LEN];

    logic [DATA_WDT-1:0]        w_res [VECT_LEN];

    logic                         r_out_val, r_out_last;
    logic [1:0]                   r_out_type;
    logic [VECT_LEN*DATA_WDT-1:0] r_out_data;

    assign w_is_data = (i_in_type == 2'd0);
    assign w_is_bn   = (i_in_type == 2'd1);
    assign w_is_pass = i_in_type[1];

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) r_state <= StIdle;
        else                   r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc       = 1'b0;
        w_ld_scale  = 1'b0;
        w_ld_shift  = 1'b0;
        w_unity     = 1'b0;
        w_cap       = 1'b0;
        w_err_set   = 1'b0;
        if (i_clk_en) begin
            // PASS vectors ride the pipe in every state
            if (i_in_val && w_is_pass) w_acc = 1'b1;
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_cap       = 1'b1;
                        w_unity     = !i_bn_en;
                        w_state_nxt = i_bn_en ? StLdScale : StProc;
                    end
                    if (i_in_val && !w_is_pass) w_err_set = 1'b1;
                end
                StLdScale: begin
                    if (i_in_val && w_is_bn) begin
                        w_ld_scale  = 1'b1;
                        w_state_nxt = StLdShift;
                    end else if (i_in_val && w_is_data) begin
                        w_err_set = 1'b1;
                    end
                end
                StLdShift: begin
                    if (i_in_val && w_is_bn) begin
                        w_ld_shift  = 1'b1;
                        w_state_nxt = StProc;
                    end else if (i_in_val && w_is_data) begin
                        w_err_set = 1'b1;
                    end
                end
                StProc: begin
                    if (i_in_val && w_is_data) begin
                        w_acc = 1'b1;
                        if (i_in_last) w_state_nxt = StIdle;
                    end else if (i_in_val && w_is_bn) begin
                        w_err_set = 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_err  <= 1'b0;
            r_relu <= 1'b0;
            for (int i = 0; i < VECT_LEN; i++) begin
                r_scale[i] <= UNITY;
                r_shift[i] <= '0;
            end
        end else begin
            if (w_err_set) r_err  <= 1'b1;
            if (w_cap)     r_relu <= i_relu_en;
            for (int i = 0; i < VECT_LEN; i++) begin
                if (w_unity) begin
                    r_scale[i] <= UNITY;
                    r_shift[i] <= '0;
                end
                if (w_ld_scale) r_scale[i] <= w_lane[i];
                if (w_ld_shift) r_shift[i] <= w_lane[i];
            end
        end
    end

    // PASS is pushed through as x*1.0 + 0, which round-trips bit-exact
    always_comb begin
        for (int i = 0; i < VECT_LEN; i++) begin
            w_lane[i] = i_in_data[i*DATA_WDT +: DATA_WDT];
            if (w_is_data) begin
                w_prod[i]  = PROD_W'(w_lane[i]) * PROD_W'(r_scale[i]);
                w_shsel[i] = r_shift[i];
            end else begin
                w_prod[i]  = PROD_W'(w_lane[i]) <<< FRAC_WDT;
                w_shsel[i] = '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < VECT_LEN; i++) begin
            w_pext[i] = SUM_W'(r_s1_prod[i]);
            w_rnd[i]  = (w_pext[i] + HALF) >>> FRAC_WDT;
            w_sum[i]  = w_rnd[i] + SUM_W'(r_s1_shift[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < VECT_LEN; i++) begin
            if (r_s2_sum[i] > SAT_MAX)      w_res[i] = SAT_MAX_W;
            else if (r_s2_sum[i] < SAT_MIN) w_res[i] = SAT_MIN_W;
            else                            w_res[i] = r_s2_sum[i][DATA_WDT-1:0];
            if (r_s2_relu && w_res[i][DATA_WDT-1]) w_res[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_s1_val   <= 1'b0;
            r_s2_val   <= 1'b0;
            r_out_val  <= 1'b0;
            r_out_type <= 2'd0;
            r_out_last <= 1'b0;
            r_out_data <= '0;
        end else if (i_clk_en) begin
            r_s1_val  <= w_acc;
            r_s2_val  <= r_s1_val;
            r_out_val <= r_s2_val;
            if (w_acc) begin
                r_s1_type <= i_in_type;
                r_s1_last <= i_in_last;
                r_s1_relu <= r_relu && w_is_data;
                for (int i = 0; i < VECT_LEN; i++) begin
                    r_s1_prod[i]  <= w_prod[i];
                    r_s1_shift[i] <= w_shsel[i];
                end
            end
            if (r_s1_val) begin
                r_s2_type <= r_s1_type;
                r_s2_last <= r_s1_last;
                r_s2_relu <= r_s1_relu;
                for (int i = 0; i < VECT_LEN; i++) r_s2_sum[i] <= w_sum[i];
            end
            if (r_s2_val) begin
                r_out_type <= r_s2_type;
                r_out_last <= r_s2_last;
                for (int i = 0; i < VECT_LEN; i++) r_out_data[i*DATA_WDT +: DATA_WDT] <= w_res[i];
            end
        end
    end

    assign o_out_val  = r_out_val;
    assign o_out_type = r_out_type;
    assign o_out_last = r_out_last;
    assign o_out_data = r_out_data;
    assign o_busy     = (r_state != StIdle);
    assign o_err      = r_err;

endmodule

// File: tb/tb_sys_arr_bn_act.sv
// Directed bench for sys_arr_bn_act: vector table of whole transfers plus
// hand sequences for protocol errors, stalls and mid-stream clear.
module tb_sys_arr_bn_act;

    localparam int VL = 8;
    localparam int DW = 16;
    localparam int BW = VL * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          bn_en = 1'b0;
    logic          relu_en = 1'b0;
    logic          in_val = 1'b0;
    logic [1:0]    in_type = 2'd0;
    logic          in_last = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          out_val;
    logic [1:0]    out_type;
    logic          out_last;
    logic [BW-1:0] out_data;
    logic          busy;
    logic          err;

    int n_vec  = 0;
    int n_fail = 0;

    sys_arr_bn_act #(.VECT_LEN(VL), .DATA_WDT(DW), .FRAC_WDT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clk_en   (clk_en),
        .i_clear    (clear),
        .i_start    (start),
        .i_bn_en    (bn_en),
        .i_relu_en  (relu_en),
        .i_in_val   (in_val),
        .i_in_type  (in_type),
        .i_in_last  (in_last),
        .i_in_data  (in_data),
        .o_out_val  (out_val),
        .o_out_type (out_type),
        .o_out_last (out_last),
        .o_out_data (out_data),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bn;
        logic        relu;
        logic [15:0] scale;
        logic [15:0] shift;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic l, input logic [BW-1:0] d);
        in_val  = 1'b1;
        in_type = t;
        in_last = l;
        in_data = d;
        tick();
        in_val  = 1'b0;
        in_last = 1'b0;
        in_type = 2'd0;
    endtask

    task automatic do_start(input logic bn, input logic relu);
        start   = 1'b1;
        bn_en   = bn;
        relu_en = relu;
        tick();
        start   = 1'b0;
    endtask

    function automatic logic [BW-1:0] pack2(input logic [15:0] a, input logic [15:0] b);
        logic [BW-1:0] r;
        for (int i = 0; i < VL; i++) r[i*DW +: DW] = (i % 2 == 0) ? a : b;
        return r;
    endfunction

    // Reference arithmetic for the stall stream, in plain 64-bit integers
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] sc,
                                          input logic [15:0] sh);
        longint p, s;
        p = longint'($signed(x)) * longint'($signed(sc));
        s = ((p + 64'sd128) >>> 8) + longint'($signed(sh));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic logic [15:0] lane_val(input int k, input int i);
        int v;
        v = k * 1117 + i * 4099 + 40000;
        return v[15:0];
    endfunction

    function automatic logic [BW-1:0] stream_in(input int k);
        logic [BW-1:0] r;
        for (int i = 0; i < VL; i++) r[i*DW +: DW] = lane_val(k, i);
        return r;
    endfunction

    function automatic logic [BW-1:0] stream_exp(input int k);
        logic [BW-1:0] r;
        for (int i = 0; i < VL; i++) r[i*DW +: DW] = model(lane_val(k, i), 16'h0180, 16'hFFF0);
        return r;
    endfunction

    initial begin
        int sent, got, cyc_cnt, hold_err, vcnt;
        logic en;
        logic [BW-1:0] pre_data;
        logic pre_val, pre_busy;

        //          bn    relu  scale     shift     d0        d1        e0        e1
        tbl[0] = '{1'b1, 1'b0, 16'h0180, 16'h0040, 16'h0200, 16'h0200, 16'h0340, 16'h0340};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        tbl[3] = '{1'b1, 1'b0, 16'h0080, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 16'h0100, 16'h0000, 16'hFF00, 16'h0100, 16'h0000, 16'h0100};
        tbl[5] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h0005, 16'h0000, 16'h0005};
        tbl[7] = '{1'b1, 1'b0, 16'h0100, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
        tbl[8] = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0100, 16'h8000, 16'hFF00, 16'h7FFF};

        tick();
        tick();
        chk("rst_out_val", BW'(out_val), BW'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_err", BW'(err), BW'(0));
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) begin
            do_start(tbl[k].bn, tbl[k].relu);
            chk($sformatf("v%0d_busy_hi", k), BW'(busy), BW'(1));
            if (tbl[k].bn) begin
                send(2'd1, 1'b0, pack2(tbl[k].scale, tbl[k].scale));
                send(2'd1, 1'b0, pack2(tbl[k].shift, tbl[k].shift));
            end
            send(2'd0, 1'b1, pack2(tbl[k].d0, tbl[k].d1));
            chk($sformatf("v%0d_busy_fall", k), BW'(busy), BW'(0));
            tick();
            chk($sformatf("v%0d_early_val", k), BW'(out_val), BW'(0));
            tick();
            chk($sformatf("v%0d_val", k), BW'(out_val), BW'(1));
            chk($sformatf("v%0d_last", k), BW'(out_last), BW'(1));
            chk($sformatf("v%0d_type", k), BW'(out_type), BW'(0));
            chk($sformatf("v%0d_data", k), out_data, pack2(tbl[k].e0, tbl[k].e1));
            tick();
            chk($sformatf("v%0d_val_drop", k), BW'(out_val), BW'(0));
        end
        chk("tbl_err_clean", BW'(err), BW'(0));

        // Stall stream: 16 DATA vectors with clk_en toggling
        do_start(1'b1, 1'b0);
        send(2'd1, 1'b0, pack2(16'h0180, 16'h0180));
        send(2'd1, 1'b0, pack2(16'hFFF0, 16'hFFF0));
        sent = 0;
        got = 0;
        cyc_cnt = 0;
        hold_err = 0;
        while ((sent < 16 || got < 16) && cyc_cnt < 400) begin
            en = (cyc_cnt % 5 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            clk_en = en;
            if (sent < 16) begin
                in_val  = 1'b1;
                in_type = 2'd0;
                in_last = (sent == 15);
                in_data = stream_in(sent);
            end else begin
                in_val  = 1'b0;
                in_last = 1'b0;
            end
            pre_data = out_data;
            pre_val  = out_val;
            pre_busy = busy;
            tick();
            cyc_cnt++;
            if (en) begin
                if (sent < 16) sent++;
                if (out_val) begin
                    if (got < 16) begin
                        chk($sformatf("stall_data%0d", got), out_data, stream_exp(got));
                        chk($sformatf("stall_last%0d", got), BW'(out_last), BW'(got == 15));
                    end else begin
                        chk("stall_extra_out", BW'(out_val), BW'(0));
                    end
                    got++;
                end
            end else if (out_data !== pre_data || out_val !== pre_val || busy !== pre_busy) begin
                hold_err++;
            end
        end
        in_val = 1'b0;
        in_last = 1'b0;
        clk_en = 1'b1;
        chk("stall_count", BW'(got), BW'(16));
        chk("stall_hold", BW'(hold_err), BW'(0));
        tick();

        // DATA while loading scale: dropped, err set, state kept
        chk("prot_err_pre", BW'(err), BW'(0));
        do_start(1'b1, 1'b0);
        send(2'd0, 1'b0, pack2(16'h0050, 16'h0050));
        chk("prot_err_set", BW'(err), BW'(1));
        chk("prot_busy", BW'(busy), BW'(1));
        tick();
        tick();
        chk("prot_no_out", BW'(out_val), BW'(0));
        send(2'd1, 1'b0, pack2(16'h0200, 16'h0200));
        send(2'd1, 1'b0, pack2(16'h0001, 16'h0001));
        send(2'd0, 1'b1, pack2(16'h0010, 16'hFFF0));
        tick();
        tick();
        chk("prot_val", BW'(out_val), BW'(1));
        chk("prot_data", out_data, pack2(16'h0021, 16'hFFE1));
        chk("prot_err_sticky", BW'(err), BW'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("prot_err_rst", BW'(err), BW'(0));

        // PASS in IDLE goes through unchanged
        send(2'd2, 1'b1, pack2(16'h1234, 16'h1234));
        tick();
        tick();
        chk("pass_val", BW'(out_val), BW'(1));
        chk("pass_type", BW'(out_type), BW'(2));
        chk("pass_last", BW'(out_last), BW'(1));
        chk("pass_data", out_data, pack2(16'h1234, 16'h1234));
        chk("pass_err", BW'(err), BW'(0));
        send(2'd3, 1'b0, pack2(16'h8765, 16'h7FFF));
        tick();
        tick();
        chk("pass3_type", BW'(out_type), BW'(3));
        chk("pass3_last", BW'(out_last), BW'(0));
        chk("pass3_data", out_data, pack2(16'h8765, 16'h7FFF));
        chk("pass3_busy", BW'(busy), BW'(0));

        // Clear with three vectors in flight, clk_en low
        do_start(1'b1, 1'b0);
        send(2'd1, 1'b0, pack2(16'h0200, 16'h0200));
        send(2'd1, 1'b0, pack2(16'h0000, 16'h0000));
        send(2'd0, 1'b0, pack2(16'h0100, 16'h0100));
        send(2'd0, 1'b0, pack2(16'h0101, 16'h0101));
        send(2'd0, 1'b0, pack2(16'h0102, 16'h0102));
        chk("clr_pre_val", BW'(out_val), BW'(1));
        clk_en = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        clk_en = 1'b1;
        chk("clr_val", BW'(out_val), BW'(0));
        chk("clr_data", out_data, '0);
        chk("clr_last", BW'(out_last), BW'(0));
        chk("clr_busy", BW'(busy), BW'(0));
        chk("clr_err", BW'(err), BW'(0));
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_val) vcnt++;
        end
        chk("clr_no_out", BW'(vcnt), BW'(0));
        do_start(1'b0, 1'b0);
        chk("clr_restart_busy", BW'(busy), BW'(1));
        send(2'd0, 1'b1, pack2(16'h0300, 16'hFD00));
        tick();
        tick();
        chk("clr_unity_val", BW'(out_val), BW'(1));
        chk("clr_unity_data", out_data, pack2(16'h0300, 16'hFD00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_arr_bn_act.md
# sys_arr_bn_act

Post-processing stage directly downstream of the systolic array. It consumes the array's output vector stream, latches per-channel batch-norm scale/shift vectors forwarded through the array, and applies y = sat(round(x·scale) + shift) with optional ReLU to every data vector. Results go to the next pipeline stage. Stall and clear follow the processing-pipe convention.

## Interface
- VECT_LEN, 8: lanes per vector.
- DATA_WDT, 16: signed lane width.
- FRAC_WDT, 8: fractional bits (fixed point Q(DATA_WDT-FRAC_WDT).FRAC_WDT); must be ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- clk_en  in  1  pipe step; all registers hold when low.
- clear  in  1  synchronous pipe clear, same effect as rst_n.
- start  in  1  transfer start, sampled only in IDLE with clk_en.
- bn_en  in  1  batch-norm enable, sampled with start.
- relu_en  in  1  ReLU enable, sampled with start.
- in_val  in  1  input vector valid.
- in_type  in  2  0 = DATA, 1 = BN_PARAM, 2/3 = PASS.
- in_last  in  1  last data vector of the transfer.
- in_data  in  VECT_LEN·DATA_WDT  lane i at bits [i·DATA_WDT +: DATA_WDT].
- out_val  out  1  output valid; reset 0.
- out_type  out  2  type forwarded; reset 0.
- out_last  out  1  forwarded last; reset 0.
- out_data  out  VECT_LEN·DATA_WDT  result; reset 0.
- busy  out  1  high when state ≠ IDLE; reset 0.
- err  out  1  sticky protocol error, cleared only by rst_n/clear; reset 0.

## Operation
- The FSM has four states: IDLE, LD_SCALE, LD_SHIFT, PROC.
  - IDLE: start with bn_en → LD_SCALE. Start without bn_en → PROC, with scale regs set to 1.0 (1<<FRAC_WDT) and shift regs set to 0.
  - LD_SCALE: a valid BN_PARAM vector is written to the scale regs → LD_SHIFT.
  - LD_SHIFT: a valid BN_PARAM vector is written to the shift regs → PROC.
  - PROC: a valid DATA vector with in_last → IDLE once that vector has been accepted.
- BN_PARAM vectors are consumed and never emitted; their in_last is ignored.
- DATA arriving in LD_SCALE/LD_SHIFT, or BN_PARAM arriving in PROC/IDLE: the vector is dropped, err is set, and the state is unchanged.
- DATA in IDLE is dropped and sets err.
- PASS vectors are forwarded unmodified (type and last preserved) in any state, with the same latency as DATA.
- A start outside IDLE is ignored. bn_en/relu_en are only captured in IDLE.
- Per-lane arithmetic on DATA:
  - p = x·scale, 2·DATA_WDT signed.
  - r = (p + 2^(FRAC_WDT-1)) >>> FRAC_WDT, arithmetic shift, i.e. round half up.
  - s = r + sign-extended shift.
  - Saturate s to [-2^(DATA_WDT-1), 2^(DATA_WDT-1)-1].
  - If relu_en, negative results become 0.
- Intermediate widths must be large enough that no wrap occurs before saturation.

## Timing
- Three-stage pipeline, latency 3 enabled cycles:
  - S1: register the product.
  - S2: round and add shift.
  - S3: saturate, apply ReLU, register the outputs.
- Throughput is one vector per enabled cycle.
- With clk_en low, all state, parameter and pipeline registers hold, and outputs hold their last value.
- Scale/shift written in cycle n apply to DATA accepted in cycle n+1 onward. Back-to-back BN_PARAM, BN_PARAM, DATA is legal with no bubble.
- Entering IDLE on the last vector does not flush the pipeline. The outputs of vectors in flight still emerge over the next 3 enabled cycles.
- A start may be accepted in the cycle after the last vector.
- rst_n or clear mid-transfer:
  - Next cycle: state = IDLE; out_val/out_type/out_last/out_data/busy/err = 0.
  - Pipeline valids are cleared and in-flight vectors are lost.
  - Scale regs return to 1.0, shift regs to 0.
  - clear acts regardless of clk_en.

## Test plan
- Basic batch norm, DATA_WDT=16, FRAC_WDT=8, bn_en=1: scale 0x0180 and shift 0x0040 on all lanes; DATA 0x0200 with last → 3 enabled cycles later out_val=1, all lanes 0x0340, out_last=1; busy falls the cycle after acceptance.
- Saturation and rounding, no bn_en (unity scale/zero shift):
  - DATA 0x7FFF → 0x7FFF.
  - With bn_en, scale 0x7FFF, shift 0x7FFF: DATA 0x7FFF → 0x7FFF; DATA 0x8000 with scale 0x7FFF → 0x8000 region saturates to 0x8000.
  - DATA 0x0001, scale 0x0080 → 0x0001 (round half up).
- ReLU: scale 0x0100, shift 0; DATA lanes 0xFF00/0x0100 → with relu_en 0x0000/0x0100; without relu_en 0xFF00/0x0100.
- Stall: toggle clk_en pseudo-randomly during a 16-vector stream → outputs are bit-identical to the unstalled reference, and nothing changes while clk_en=0.
- Protocol errors: DATA in LD_SCALE → dropped, err=1, state stays LD_SCALE. PASS vector 0x1234 in IDLE → emitted unchanged after 3 cycles, err unaffected.
- clear mid-stream: clear asserted while 3 vectors are in flight → next cycle all outputs 0, busy=0, no further out_val; a following start with bn_en=0 processes DATA with unity scale.
